// File: rtl/sdfa_sram_ctrl_pkg.sv
// Shared geometry and FSM encoding for the 80-neuron weight SRAM controller.
package sdfa_sram_ctrl_pkg;

    localparam int NUMBER_OF_BANK = 10;
    localparam int BANK_BIT       = 112;
    localparam int MEM_SIZE_BIT   = 8;
    localparam int ROWS_W         = MEM_SIZE_BIT + 1;
    localparam int BANK_CNT_W     = 4;
    localparam int DIN_W          = NUMBER_OF_BANK * BANK_BIT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sdfa_sram_ctrl.sv
// Weight SRAM controller: streams bank-wide load beats into rows, serves
// single-row reads, and stalls the load whenever a read targets the row being filled.
module sdfa_sram_ctrl
    import sdfa_sram_ctrl_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic                      RD_REQ,
    input  logic [MEM_SIZE_BIT-1:0]   RD_ADDR,
    output logic                      RD_VALID,
    input  logic                      LOAD_START,
    input  logic [MEM_SIZE_BIT-1:0]   LOAD_BASE,
    input  logic [ROWS_W-1:0]         LOAD_ROWS,
    input  logic                      LOAD_ABORT,
    input  logic                      WR_VALID,
    output logic                      WR_READY,
    input  logic [BANK_BIT-1:0]       WR_DATA,
    output logic                      BUSY,
    output logic                      LOAD_DONE,
    output logic                      SRAM_EN_M,
    output logic [NUMBER_OF_BANK-1:0] SRAM_WE,
    output logic [MEM_SIZE_BIT-1:0]   SRAM_ADDR,
    output logic [MEM_SIZE_BIT-1:0]   SRAM_ADDR_WRITE,
    output logic [DIN_W-1:0]          SRAM_DIN
);

    // Bank 0 lives at the MSB of both WE and DIN.
    localparam logic [NUMBER_OF_BANK-1:0] WE_BANK0  = NUMBER_OF_BANK'(1) << (NUMBER_OF_BANK - 1);
    localparam logic [BANK_CNT_W-1:0]     BANK_LAST = BANK_CNT_W'(NUMBER_OF_BANK - 1);

    state_e                      state_q;
    logic [MEM_SIZE_BIT-1:0]     row_ptr_q;
    logic [ROWS_W-1:0]           rows_left_q;
    logic [BANK_CNT_W-1:0]       bank_cnt_q;
    logic [NUMBER_OF_BANK-1:0]   we_q;
    logic [MEM_SIZE_BIT-1:0]     addr_w_q;
    logic [MEM_SIZE_BIT-1:0]     addr_r_q;
    logic [DIN_W-1:0]            din_q;
    logic                        en_q;
    logic [RD_LAT:0]             vld_pipe_q;

    logic rd_hit;
    logic beat;

    assign rd_hit   = RD_REQ && (RD_ADDR == row_ptr_q);
    assign WR_READY = (state_q == LOAD) && !LOAD_ABORT && !rd_hit;
    assign beat     = WR_VALID && WR_READY;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            row_ptr_q   <= '0;
            rows_left_q <= '0;
            bank_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (LOAD_START) begin
                        row_ptr_q   <= LOAD_BASE;
                        rows_left_q <= LOAD_ROWS;
                        bank_cnt_q  <= '0;
                        state_q     <= (LOAD_ROWS == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (LOAD_ABORT) begin
                        state_q <= IDLE;
                    end else if (beat) begin
                        if (bank_cnt_q == BANK_LAST) begin
                            bank_cnt_q  <= '0;
                            row_ptr_q   <= row_ptr_q + MEM_SIZE_BIT'(1);
                            rows_left_q <= rows_left_q - ROWS_W'(1);
                            if (rows_left_q == ROWS_W'(1)) state_q <= DONE;
                        end else begin
                            bank_cnt_q <= bank_cnt_q + BANK_CNT_W'(1);
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // SRAM-side registers: WE pulses per accepted beat, address/data hold between writes.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            we_q       <= '0;
            addr_w_q   <= '0;
            addr_r_q   <= '0;
            din_q      <= '0;
            en_q       <= 1'b0;
            vld_pipe_q <= '0;
        end else begin
            we_q       <= '0;
            en_q       <= RD_REQ || beat;
            vld_pipe_q <= {vld_pipe_q[RD_LAT-1:0], RD_REQ};
            if (beat) begin
                we_q     <= WE_BANK0 >> bank_cnt_q;
                addr_w_q <= row_ptr_q;
                din_q    <= {NUMBER_OF_BANK{WR_DATA}};
            end
            if (RD_REQ) addr_r_q <= RD_ADDR;
        end
    end

    assign BUSY            = (state_q == LOAD);
    assign LOAD_DONE       = (state_q == DONE);
    assign RD_VALID        = vld_pipe_q[RD_LAT];
    assign SRAM_EN_M       = en_q;
    assign SRAM_WE         = we_q;
    assign SRAM_ADDR       = addr_r_q;
    assign SRAM_ADDR_WRITE = addr_w_q;
    assign SRAM_DIN        = din_q;

endmodule

// File: tb/tb_sdfa_sram_ctrl.sv
// Bench for sdfa_sram_ctrl: beat-count model checked every cycle, plus literal
// expectations for the directed load/read/abort/reset scenarios.
module tb_sdfa_sram_ctrl;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b1;
    logic          RD_REQ = 1'b0;
    logic [7:0]    RD_ADDR = '0;
    logic          RD_VALID;
    logic          LOAD_START = 1'b0;
    logic [7:0]    LOAD_BASE = '0;
    logic [8:0]    LOAD_ROWS = '0;
    logic          LOAD_ABORT = 1'b0;
    logic          WR_VALID = 1'b0;
    logic          WR_READY;
    logic [111:0]  WR_DATA = '0;
    logic          BUSY;
    logic          LOAD_DONE;
    logic          SRAM_EN_M;
    logic [9:0]    SRAM_WE;
    logic [7:0]    SRAM_ADDR;
    logic [7:0]    SRAM_ADDR_WRITE;
    logic [1119:0] SRAM_DIN;

    always #5 CLK = ~CLK;

    sdfa_sram_ctrl dut (
        .CLK(CLK), .RSTN(RSTN), .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR), .RD_VALID(RD_VALID),
        .LOAD_START(LOAD_START), .LOAD_BASE(LOAD_BASE), .LOAD_ROWS(LOAD_ROWS),
        .LOAD_ABORT(LOAD_ABORT), .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_DATA(WR_DATA),
        .BUSY(BUSY), .LOAD_DONE(LOAD_DONE), .SRAM_EN_M(SRAM_EN_M), .SRAM_WE(SRAM_WE),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_ADDR_WRITE(SRAM_ADDR_WRITE), .SRAM_DIN(SRAM_DIN)
    );

    // Model: a load is "beat k of rows*10"; beat k goes to bank k%10 of row base+k/10.
    bit           m_loading, e_done, e_en, e_rv, m_rd_d1;
    int           m_base, m_rows, m_k;
    logic [9:0]   e_we;
    logic [7:0]   e_aw, e_ra;
    logic [111:0] e_din;

    int m_tests = 0, m_fails = 0, l_tests = 0, l_fails = 0;
    int n_wr = 0, n_done = 0, n_rv = 0;
    logic [9:0]  wr_we   [0:255];
    logic [7:0]  wr_addr [0:255];
    logic [31:0] wr_d0   [0:255];

    function automatic int cur_row();
        return (m_base + m_k / 10) % 256;
    endfunction

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            m_loading = 0; e_done = 0; e_en = 0; e_rv = 0; m_rd_d1 = 0;
            m_base = 0; m_rows = 0; m_k = 0;
            e_we = '0; e_aw = '0; e_ra = '0; e_din = '0;
        end else begin
            bit acc, nd;
            acc = m_loading && WR_VALID && !LOAD_ABORT && !(RD_REQ && int'(RD_ADDR) == cur_row());
            e_we = acc ? (10'h200 >> (m_k % 10)) : 10'h000;
            if (acc) begin
                e_aw  = 8'(cur_row());
                e_din = WR_DATA;
            end
            e_en = RD_REQ || acc;
            if (RD_REQ) e_ra = RD_ADDR;
            e_rv    = m_rd_d1;
            m_rd_d1 = RD_REQ;
            nd = 0;
            if (!m_loading && !e_done && LOAD_START) begin
                m_base = int'(LOAD_BASE);
                m_rows = int'(LOAD_ROWS);
                m_k    = 0;
                if (LOAD_ROWS == 0) nd = 1;
                else m_loading = 1;
            end else if (m_loading) begin
                if (LOAD_ABORT) m_loading = 0;
                else if (acc) begin
                    m_k++;
                    if (m_k == m_rows * 10) begin
                        m_loading = 0;
                        nd = 1;
                    end
                end
            end
            e_done = nd;
        end
    end

    task automatic mchk(input string name, input logic [31:0] act, input logic [31:0] exp);
        m_tests++;
        if (act !== exp) begin
            m_fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        mchk("busy", 32'(BUSY), 32'(m_loading));
        mchk("load_done", 32'(LOAD_DONE), 32'(e_done));
        mchk("wr_ready", 32'(WR_READY),
             32'(m_loading && !LOAD_ABORT && !(RD_REQ && int'(RD_ADDR) == cur_row())));
        mchk("sram_we", 32'(SRAM_WE), 32'(e_we));
        mchk("addr_write", 32'(SRAM_ADDR_WRITE), 32'(e_aw));
        mchk("sram_addr", 32'(SRAM_ADDR), 32'(e_ra));
        mchk("en_m", 32'(SRAM_EN_M), 32'(e_en));
        mchk("rd_valid", 32'(RD_VALID), 32'(e_rv));
        m_tests++;
        if (SRAM_DIN !== {10{e_din}}) begin
            m_fails++;
            $display("FAIL sram_din @%0t: bank0 slice got %0h expected %0h",
                     $time, SRAM_DIN[1119 -: 112], e_din);
        end
        if (SRAM_WE != '0 && n_wr < 256) begin
            wr_we[n_wr]   = SRAM_WE;
            wr_addr[n_wr] = SRAM_ADDR_WRITE;
            wr_d0[n_wr]   = SRAM_DIN[1039 -: 32];
        end
        if (SRAM_WE != '0) n_wr++;
        if (LOAD_DONE) n_done++;
        if (RD_VALID) n_rv++;
    end

    task automatic lchk(input string name, input logic [31:0] act, input logic [31:0] exp);
        l_tests++;
        if (act !== exp) begin
            l_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic start(input int base, input int rows);
        LOAD_BASE  = 8'(base);
        LOAD_ROWS  = 9'(rows);
        LOAD_START = 1'b1;
        cyc(1);
        LOAD_START = 1'b0;
    endtask

    // Sends n beats carrying data 0..n-1, advancing only on accepted beats.
    task automatic beats(input int n);
        int  k = 0;
        int  guard = 0;
        logic rdy;
        WR_VALID = 1'b1;
        WR_DATA  = 112'(k);
        while (k < n && guard < 200) begin
            @(negedge CLK);
            rdy = WR_READY;
            cyc(1);
            if (rdy) begin
                k++;
                WR_DATA = 112'(k);
            end
            guard++;
        end
        WR_VALID = 1'b0;
        lchk("beats_accepted", 32'(k), 32'(n));
    endtask

    initial begin
        int s, d, r, stall_n;
        #1 RSTN = 1'b0;
        #1;
        lchk("rst_busy", 32'(BUSY), 0);
        lchk("rst_we", 32'(SRAM_WE), 0);
        lchk("rst_en", 32'(SRAM_EN_M), 0);
        lchk("rst_din", 32'(SRAM_DIN != '0), 0);
        cyc(2);
        RSTN = 1'b1;
        cyc(2);

        // Two rows from row 3, data = beat index.
        s = n_wr; d = n_done;
        start(3, 2);
        beats(20);
        cyc(3);
        lchk("t1_nwr", 32'(n_wr - s), 20);
        lchk("t1_done", 32'(n_done - d), 1);
        lchk("t1_we_first", 32'(wr_we[s]), 32'h200);
        lchk("t1_aw_first", 32'(wr_addr[s]), 3);
        lchk("t1_d0_first", wr_d0[s], 0);
        lchk("t1_we_bank9", 32'(wr_we[s+9]), 32'h001);
        lchk("t1_aw_row2", 32'(wr_addr[s+10]), 4);
        lchk("t1_d_last", wr_d0[s+19], 19);
        lchk("t1_busy", 32'(BUSY), 0);

        // Row pointer wraps 255 -> 0.
        s = n_wr; d = n_done;
        start(255, 2);
        beats(20);
        cyc(3);
        lchk("t2_nwr", 32'(n_wr - s), 20);
        lchk("t2_aw_255", 32'(wr_addr[s+9]), 255);
        lchk("t2_aw_wrap", 32'(wr_addr[s+10]), 0);
        lchk("t2_done", 32'(n_done - d), 1);

        // Read of the row being loaded stalls it; read of another row does not.
        s = n_wr; d = n_done; r = n_rv; stall_n = 0;
        start(7, 1);
        beats(4);
        WR_VALID = 1'b1; WR_DATA = 112'(4); RD_REQ = 1'b1; RD_ADDR = 8'd7;
        repeat (3) begin
            @(negedge CLK);
            if (!WR_READY) stall_n++;
            cyc(1);
        end
        RD_ADDR = 8'd9;
        @(negedge CLK);
        lchk("conc_ready", 32'(WR_READY), 1);
        cyc(1);
        RD_REQ = 1'b0; WR_VALID = 1'b0;
        @(negedge CLK);
        lchk("conc_we", 32'(SRAM_WE), 32'h020);
        lchk("conc_addr", 32'(SRAM_ADDR), 9);
        lchk("conc_en", 32'(SRAM_EN_M), 1);
        cyc(1);
        beats(5);
        cyc(3);
        lchk("stall_cycles", 32'(stall_n), 3);
        lchk("stall_nwr", 32'(n_wr - s), 10);
        lchk("stall_resume_we", 32'(wr_we[s+4]), 32'h020);
        lchk("stall_aw", 32'(wr_addr[s+9]), 7);
        lchk("stall_rv", 32'(n_rv - r), 4);
        lchk("stall_done", 32'(n_done - d), 1);

        // Abort with a beat pending after 13 beats.
        s = n_wr; d = n_done;
        start(20, 2);
        beats(13);
        WR_VALID = 1'b1; LOAD_ABORT = 1'b1;
        @(negedge CLK);
        lchk("abort_ready", 32'(WR_READY), 0);
        cyc(1);
        LOAD_ABORT = 1'b0; WR_VALID = 1'b0;
        @(negedge CLK);
        lchk("abort_busy", 32'(BUSY), 0);
        lchk("abort_we", 32'(SRAM_WE), 0);
        cyc(3);
        lchk("abort_nwr", 32'(n_wr - s), 13);
        lchk("abort_done", 32'(n_done - d), 0);

        // Zero-row load completes immediately.
        s = n_wr; d = n_done;
        start(40, 0);
        @(negedge CLK);
        lchk("zero_done", 32'(LOAD_DONE), 1);
        cyc(3);
        lchk("zero_nwr", 32'(n_wr - s), 0);
        lchk("zero_ndone", 32'(n_done - d), 1);

        // Reset mid-load, right after a write was issued.
        d = n_done;
        start(50, 3);
        beats(5);
        #2 RSTN = 1'b0;
        #1;
        lchk("mid_rst_we", 32'(SRAM_WE), 0);
        lchk("mid_rst_busy", 32'(BUSY), 0);
        lchk("mid_rst_en", 32'(SRAM_EN_M), 0);
        lchk("mid_rst_aw", 32'(SRAM_ADDR_WRITE), 0);
        lchk("mid_rst_din", 32'(SRAM_DIN != '0), 0);
        cyc(2);
        RSTN = 1'b1;
        cyc(1);
        lchk("mid_rst_nodone", 32'(n_done - d), 0);
        s = n_wr; d = n_done;
        start(60, 1);
        beats(10);
        cyc(3);
        lchk("post_rst_nwr", 32'(n_wr - s), 10);
        lchk("post_rst_aw", 32'(wr_addr[s]), 60);
        lchk("post_rst_done", 32'(n_done - d), 1);

        $display("[TB] %0d tests run, %0d failed", m_tests + l_tests, m_fails + l_fails);
        $finish;
    end

endmodule
